// File: rtl/karatsuba_seq_20.sv
// Sequential 20x20 carry-less (GF(2)[x]) multiplier.
// One 10x10 Karatsuba core is reused over three cycles (hi*hi, lo*lo,
// mid*mid), then the three partial products are recombined with XOR.

// 10x10 -> 19-bit carry-less multiply, one Karatsuba level over 5-bit halves
module karatsuba_mult_10 (
  input  logic [9:0]  a,
  input  logic [9:0]  b,
  output logic [18:0] p
);
  // 5x5 schoolbook carry-less product
  function automatic logic [8:0] clmul5(input logic [4:0] x, input logic [4:0] y);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < 5; i++)
      if (y[i]) r = r ^ (9'(x) << i);
    return r;
  endfunction

  logic [8:0] p_hh, p_ll, p_m;

  // three half products and XOR recombination; no carries anywhere
  always_comb begin
    p_hh = clmul5(a[9:5], b[9:5]);
    p_ll = clmul5(a[4:0], b[4:0]);
    p_m  = clmul5(a[9:5] ^ a[4:0], b[9:5] ^ b[4:0]);
    p    = (19'(p_hh) << 10) ^ (19'(p_m ^ p_hh ^ p_ll) << 5) ^ 19'(p_ll);
  end
endmodule

module karatsuba_seq_20 #(
  parameter int W  = 20,
  parameter int PW = 39
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] C,
  output logic          busy
);
  localparam int H = W / 2;

  typedef enum logic [2:0] {IDLE, MUL_HH, MUL_LL, MUL_MID, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_reg, b_reg;
  logic [2*H-2:0]  p_hh, p_ll, prod;
  logic [H-1:0]    m_a, m_b;
  logic [PW-1:0]   c_next;

  // operand mux for the shared core; idle/done drive zeros to keep it quiet
  always_comb begin
    m_a = '0;
    m_b = '0;
    case (state)
      MUL_HH:  begin m_a = a_reg[W-1:H];              m_b = b_reg[W-1:H];              end
      MUL_LL:  begin m_a = a_reg[H-1:0];              m_b = b_reg[H-1:0];              end
      MUL_MID: begin m_a = a_reg[W-1:H] ^ a_reg[H-1:0]; m_b = b_reg[W-1:H] ^ b_reg[H-1:0]; end
      default: ;
    endcase
  end

  karatsuba_mult_10 u_mult (.a(m_a), .b(m_b), .p(prod));

  // final recombination, valid while the core holds the middle product
  always_comb
    c_next = (PW'(p_hh) << W) ^ (PW'(prod ^ p_hh ^ p_ll) << H) ^ PW'(p_ll);

  // control FSM with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      C         <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      p_hh      <= '0;
      p_ll      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg    <= A;
          b_reg    <= B;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= MUL_HH;
        end
        MUL_HH: begin
          p_hh  <= prod;
          state <= MUL_LL;
        end
        MUL_LL: begin
          p_ll  <= prod;
          state <= MUL_MID;
        end
        MUL_MID: begin
          C         <= c_next;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
